atmr_vote_seq: RTL and testbench
================================

// Module: atmr_vote_seq
// PURPOSE
//  Sequences one shared combinational benchmark unit (14-in/8-out, e.g. the alu4 netlist plus its two
//  approximate variants behind a copy-select mux) in time-multiplexed approximate-TMR fashion.
//  - Accepts one operand vector per request.
//  - Evaluates it on copy 0 (original), copy 1 and copy 2 (approximate) in turn.
//  - Bitwise majority-votes the three results and returns the result with disagreement flags.
//  - Sits between the test/stimulus front end and the unit.
// PARAMETERS
//  IN_W    14  operand width driven to the unit
//  OUT_W   8   result width returned by the unit
//  SETTLE  2   cycles each copy is driven before sampling; legal 1..15
//  CNT_W   16  width of saturating disagreement counter
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  cfg_bypass  in   1      1 = evaluate copy 0 only (no voting); sampled at request accept
//  req_valid   in   1      request handshake valid
//  req_ready   out  1      block can accept a request
//  req_data    in   IN_W   operand vector
//  unit_in     out  IN_W   operand driven to the shared unit
//  unit_sel    out  2      copy select: 0 original, 1 approx A, 2 approx B (3 never driven)
//  unit_out    in   OUT_W  unit result, combinational from unit_in/unit_sel
//  rsp_valid   out  1      response handshake valid
//  rsp_ready   in   1      consumer accepts response
//  rsp_data    out  OUT_W  voted result (copy-0 result in bypass)
//  rsp_err     out  OUT_W  per-bit flag: copies not unanimous on this bit (0 in bypass)
//  rsp_fault   out  1      copy-0 result differs from voted result (0 in bypass)
//  err_cnt     out  CNT_W  saturating count of voted responses with rsp_err != 0
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE.
//    All outputs 0 (req_ready, rsp_valid, unit_in, unit_sel, rsp_*, err_cnt).
//    req_ready rises the first clock edge after rst_n deasserts.
//  - FSM states IDLE -> EVAL -> VOTE -> RESP -> IDLE.
//  - IDLE:
//    - req_ready=1.
//    - On req_valid&req_ready: latch req_data->op_q and cfg_bypass->byp_q; copy k=0, cnt=0; go EVAL.
//  - EVAL:
//    - req_ready=0; unit_in=op_q; unit_sel=k.
//    - cnt counts 0..SETTLE-1.
//    - At cnt==SETTLE-1: capture unit_out into r[k].
//      - If k==2, or byp_q with k==0: go VOTE.
//      - Otherwise: k++, cnt=0.
//    - unit_out is never sampled in the first SETTLE-1 cycles after unit_sel/unit_in change.
//  - VOTE (1 cycle):
//    - maj = (r0&r1)|(r0&r2)|(r1&r2).
//    - err = (r0^r1)|(r0^r2).
//    - fault = |(r0^maj).
//    - Register maj, err and fault into rsp_*. Bypass registers r0, 0, 0.
//    - err_cnt += (err!=0), saturating at all-ones. Never increments in bypass.
//  - RESP:
//    - rsp_valid=1; rsp_* held stable until rsp_ready.
//    - On rsp_ready: go IDLE. The new request is accepted next cycle at the earliest (no overlap).
//  - unit_in/unit_sel hold their last driven values in VOTE/RESP/IDLE. unit_sel returns to 0 only when the next EVAL starts.
//  - Latency, accept edge to rsp_valid high: 3*SETTLE+1 cycles (SETTLE+1 in bypass).
//  - cfg_bypass changes while busy have no effect on the request in flight.
//  - rsp_ready is ignored outside RESP. req_valid is ignored while req_ready=0.
//  - rst_n asserted mid-operation: in-flight request dropped, no response, err_cnt cleared to 0.
// TESTING
//  - Reset: hold rst_n=0 3 cycles -> all outputs 0. One edge after release -> req_ready=1, err_cnt=0.
//  - Unanimous, SETTLE=2: req_data=14'h1A5; unit returns 8'h3C for sel 0/1/2
//    -> rsp_valid 7 cycles after accept, rsp_data=8'h3C, rsp_err=0, rsp_fault=0, err_cnt stays 0.
//  - Vote with fault: copies return 8'hF0, 8'h0F, 8'h0F
//    -> rsp_data=8'h0F, rsp_err=8'hFF, rsp_fault=1, err_cnt 0->1.
//  - Bypass: cfg_bypass=1, copy 0 returns 8'hA5 -> unit_sel never leaves 0,
//    rsp_valid 3 cycles after accept, rsp_data=8'hA5, rsp_err=0, err_cnt unchanged.
//  - Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0 throughout, second req_valid not accepted.
//  - Saturation/reset: preload 16'hFFFF disagreements (or force) plus one more disagreeing request -> err_cnt stays 16'hFFFF.
//    rst_n pulse during EVAL -> no rsp_valid; err_cnt=0.

Source files
------------

// File: rtl/atmr_vote_seq.sv
// ---------------------------------------------------------------------------
// atmr_vote_seq
//   Time-multiplexed approximate-TMR sequencer for one shared combinational
//   unit. Each accepted operand is evaluated on copy 0 (original), then on
//   copies 1 and 2 (approximate). The three results are majority-voted
//   bitwise, and the vote is returned with per-bit disagreement flags. In
//   bypass mode only copy 0 is evaluated and its result is returned as is.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. The producer holds its data stable while valid is high and
//   ready is low. req_ready and rsp_valid are registered outputs.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   cfg_bypass   1 = copy 0 only, no voting; sampled when a request is accepted
//   req_valid/req_ready/req_data    request channel (operand)
//   unit_in/unit_sel                operand and copy select to the shared unit
//   unit_out                        unit result, combinational from unit_in/unit_sel
//   rsp_valid/rsp_ready             response channel
//   rsp_data     voted result (copy-0 result in bypass)
//   rsp_err      per-bit flag: copies not unanimous (0 in bypass)
//   rsp_fault    copy-0 result differs from the voted result (0 in bypass)
//   err_cnt      saturating count of voted responses with rsp_err != 0
//   dbg_state    current FSM state (0 IDLE, 1 EVAL, 2 VOTE, 3 RESP)
// ---------------------------------------------------------------------------
module atmr_vote_seq #(
    parameter int IN_W   = 14,
    parameter int OUT_W  = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_bypass,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IN_W-1:0]  req_data,
    output logic [IN_W-1:0]  unit_in,
    output logic [1:0]       unit_sel,
    input  logic [OUT_W-1:0] unit_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic [OUT_W-1:0] rsp_err,
    output logic             rsp_fault,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        VOTE = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last settle cycle of a copy; the unit result is captured only here.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_q;
    logic             byp_q;
    logic [1:0]       k_q;
    logic [3:0]       cnt_q;
    logic [OUT_W-1:0] r0_q, r1_q, r2_q;
    logic             req_ready_q;
    logic [IN_W-1:0]  unit_in_q;   // also serves as the latched operand
    logic [1:0]       unit_sel_q;
    logic             rsp_valid_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic [OUT_W-1:0] rsp_err_q;
    logic             rsp_fault_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [OUT_W-1:0] maj_d;
    logic [OUT_W-1:0] err_d;
    logic             fault_d;

    always_comb begin
        maj_d   = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
        err_d   = (r0_q ^ r1_q) | (r0_q ^ r2_q);
        fault_d = |(r0_q ^ maj_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byp_q       <= 1'b0;
            k_q         <= 2'd0;
            cnt_q       <= 4'd0;
            r0_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            req_ready_q <= 1'b0;
            unit_in_q   <= '0;
            unit_sel_q  <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= '0;
            rsp_fault_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        unit_in_q   <= req_data;
                        unit_sel_q  <= 2'd0;
                        byp_q       <= cfg_bypass;
                        k_q         <= 2'd0;
                        cnt_q       <= 4'd0;
                        req_ready_q <= 1'b0;
                        state_q     <= EVAL;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                EVAL: begin
                    if (cnt_q == SETTLE_LAST) begin
                        case (k_q)
                            2'd0:    r0_q <= unit_out;
                            2'd1:    r1_q <= unit_out;
                            default: r2_q <= unit_out;
                        endcase
                        if (k_q == 2'd2 || (byp_q && k_q == 2'd0)) begin
                            state_q <= VOTE;
                        end else begin
                            // Switching copy restarts the settle window.
                            k_q        <= k_q + 2'd1;
                            unit_sel_q <= k_q + 2'd1;
                            cnt_q      <= 4'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                VOTE: begin
                    if (byp_q) begin
                        rsp_data_q  <= r0_q;
                        rsp_err_q   <= '0;
                        rsp_fault_q <= 1'b0;
                    end else begin
                        rsp_data_q  <= maj_d;
                        rsp_err_q   <= err_d;
                        rsp_fault_q <= fault_d;
                        if ((err_d != '0) && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign unit_in   = unit_in_q;
    assign unit_sel  = unit_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_fault = rsp_fault_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_atmr_vote_seq.sv
// ---------------------------------------------------------------------------
// tb_atmr_vote_seq
//   Directed bench for atmr_vote_seq. A behavioural unit model returns a
//   per-copy value chosen by each test, and returns the inverted value during
//   the first cycle after unit_sel/unit_in change, so an early sample shows up
//   as a wrong result. A second instance with a 2-bit counter runs in lockstep
//   on the same stimulus to reach counter saturation quickly.
// ---------------------------------------------------------------------------
module tb_atmr_vote_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_bypass = 1'b0;
    logic        req_valid = 1'b0;
    logic [13:0] req_data = '0;
    logic        rsp_ready = 1'b0;

    logic        req_ready, rsp_valid, rsp_fault;
    logic [13:0] unit_in;
    logic [1:0]  unit_sel, dbg_state;
    logic [7:0]  unit_out, rsp_data, rsp_err;
    logic [15:0] err_cnt;

    logic        s_req_ready, s_rsp_valid, s_rsp_fault;
    logic [13:0] s_unit_in;
    logic [1:0]  s_unit_sel, s_dbg_state;
    logic [7:0]  s_rsp_data, s_rsp_err;
    logic [1:0]  s_err_cnt;

    int total = 0;
    int bad = 0;

    logic [7:0]  copy_val [3];
    logic [1:0]  prev_sel = 2'd0;
    logic [13:0] prev_in = '0;

    always #5 clk = ~clk;

    atmr_vote_seq #(.IN_W(14), .OUT_W(8), .SETTLE(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .unit_in(unit_in), .unit_sel(unit_sel), .unit_out(unit_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_fault(rsp_fault), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    // Same inputs as dut, so unit_in/unit_sel match and unit_out can be shared.
    atmr_vote_seq #(.IN_W(14), .OUT_W(8), .SETTLE(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_data(req_data),
        .unit_in(s_unit_in), .unit_sel(s_unit_sel), .unit_out(unit_out),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
        .rsp_err(s_rsp_err), .rsp_fault(s_rsp_fault), .err_cnt(s_err_cnt),
        .dbg_state(s_dbg_state)
    );

    // Unit model.
    always @(posedge clk) begin
        prev_sel <= unit_sel;
        prev_in  <= unit_in;
    end

    always_comb begin
        logic [7:0] v;
        v = (unit_sel == 2'd3) ? copy_val[0] : copy_val[unit_sel];
        unit_out = ((unit_sel != prev_sel) || (unit_in != prev_in)) ? ~v : v;
    end

    // Driver: issue one request and wait (bounded) for rsp_valid.
    // Returns at a falling edge; lat counts rising edges from the accept edge.
    task automatic run_req(input logic [13:0] data, input logic byp, input logic toggle_byp,
                           output int lat, output logic ready_seen, output logic sel_moved);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cfg_bypass = byp;
        req_valid  = 1'b1;
        req_data   = data;
        @(posedge clk);
        lat = 0;
        ready_seen = 1'b0;
        sel_moved  = 1'b0;
        #1;
        req_valid = 1'b0;
        if (toggle_byp) cfg_bypass = ~byp;
        while (lat < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (req_ready) ready_seen = 1'b1;
            if (unit_sel != 2'd0) sel_moved = 1'b1;
            @(posedge clk);
            lat++;
        end
        cfg_bypass = 1'b0;
    endtask

    // Driver: accept the pending response; returns at the following falling edge.
    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, unit_in, unit_sel, rsp_data, rsp_err, rsp_fault, err_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b vld=%b in=%h sel=%h data=%h err=%h flt=%b cnt=%h expected all 0",
                     req_ready, rsp_valid, unit_in, unit_sel, rsp_data, rsp_err, rsp_fault, err_cnt);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready_early: got %b expected 0", req_ready);
        end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || err_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_release: ready=%b cnt=%h expected ready=1 cnt=0000", req_ready, err_cnt);
        end
    endtask

    task automatic test_unanimous();
        int lat;
        logic rs, sm;
        copy_val[0] = 8'h3C; copy_val[1] = 8'h3C; copy_val[2] = 8'h3C;
        // cfg_bypass flips to 1 mid-flight; the request must still be voted.
        run_req(14'h1A5, 1'b0, 1'b1, lat, rs, sm);
        total++;
        if (lat !== 7) begin bad++; $display("FAIL unan_latency: got %0d expected 7", lat); end
        total++;
        if (rs !== 1'b0) begin bad++; $display("FAIL unan_busy_ready: got ready high while busy, expected 0"); end
        total++;
        if (rsp_data !== 8'h3C || rsp_err !== 8'h00 || rsp_fault !== 1'b0) begin
            bad++;
            $display("FAIL unan_rsp: data=%h err=%h flt=%b expected 3c 00 0", rsp_data, rsp_err, rsp_fault);
        end
        total++;
        if (err_cnt !== 16'h0 || unit_in !== 14'h1A5 || unit_sel !== 2'd2) begin
            bad++;
            $display("FAIL unan_hold: cnt=%h in=%h sel=%0d expected 0000 01a5 2", err_cnt, unit_in, unit_sel);
        end
        release_rsp();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || unit_sel !== 2'd2) begin
            bad++;
            $display("FAIL unan_release: vld=%b rdy=%b sel=%0d expected 0 1 2", rsp_valid, req_ready, unit_sel);
        end
    endtask

    task automatic test_vote();
        logic [7:0]  c0 [3] = '{8'hF0, 8'hAA, 8'h12};
        logic [7:0]  c1 [3] = '{8'h0F, 8'hAB, 8'h34};
        logic [7:0]  c2 [3] = '{8'h0F, 8'hAA, 8'h56};
        logic [7:0]  e_data [3] = '{8'h0F, 8'hAA, 8'h16};
        logic [7:0]  e_err [3] = '{8'hFF, 8'h01, 8'h66};
        logic        e_flt [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] e_cnt [3] = '{16'd1, 16'd2, 16'd3};
        logic [1:0]  e_sat [3] = '{2'd1, 2'd2, 2'd3};
        int lat;
        logic rs, sm;
        for (int i = 0; i < 3; i++) begin
            copy_val[0] = c0[i]; copy_val[1] = c1[i]; copy_val[2] = c2[i];
            run_req(14'h2000 + 14'(i), 1'b0, 1'b0, lat, rs, sm);
            total++;
            if (lat !== 7) begin bad++; $display("FAIL vote%0d_latency: got %0d expected 7", i, lat); end
            total++;
            if (rsp_data !== e_data[i] || rsp_err !== e_err[i] || rsp_fault !== e_flt[i]) begin
                bad++;
                $display("FAIL vote%0d_rsp: data=%h err=%h flt=%b expected %h %h %b",
                         i, rsp_data, rsp_err, rsp_fault, e_data[i], e_err[i], e_flt[i]);
            end
            total++;
            if (err_cnt !== e_cnt[i] || s_err_cnt !== e_sat[i]) begin
                bad++;
                $display("FAIL vote%0d_cnt: cnt=%0d sat=%0d expected %0d %0d",
                         i, err_cnt, s_err_cnt, e_cnt[i], e_sat[i]);
            end
            release_rsp();
        end
    endtask

    task automatic test_bypass();
        int lat;
        logic rs, sm;
        copy_val[0] = 8'hA5; copy_val[1] = 8'h00; copy_val[2] = 8'hFF;
        run_req(14'h002B, 1'b1, 1'b0, lat, rs, sm);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL byp_latency: got %0d expected 3", lat); end
        total++;
        if (sm !== 1'b0 || unit_sel !== 2'd0) begin
            bad++;
            $display("FAIL byp_sel: moved=%b sel=%0d expected 0 0", sm, unit_sel);
        end
        total++;
        if (rsp_data !== 8'hA5 || rsp_err !== 8'h00 || rsp_fault !== 1'b0) begin
            bad++;
            $display("FAIL byp_rsp: data=%h err=%h flt=%b expected a5 00 0", rsp_data, rsp_err, rsp_fault);
        end
        total++;
        if (err_cnt !== 16'd3 || s_err_cnt !== 2'd3) begin
            bad++;
            $display("FAIL byp_cnt: cnt=%0d sat=%0d expected 3 3", err_cnt, s_err_cnt);
        end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        logic rs, sm;
        copy_val[0] = 8'h55; copy_val[1] = 8'h55; copy_val[2] = 8'h55;
        run_req(14'h03FF, 1'b0, 1'b0, lat, rs, sm);
        total++;
        if (lat !== 7) begin bad++; $display("FAIL bp_latency: got %0d expected 7", lat); end
        req_valid = 1'b1;
        req_data  = 14'h0111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_err !== 8'h00 || rsp_fault !== 1'b0 ||
                req_ready !== 1'b0 || unit_in !== 14'h03FF) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b data=%h err=%h flt=%b rdy=%b in=%h expected 1 55 00 0 0 03ff",
                         c, rsp_valid, rsp_data, rsp_err, rsp_fault, req_ready, unit_in);
            end
        end
        req_valid = 1'b0;
        release_rsp();
        @(negedge clk);
        total++;
        if (unit_in !== 14'h03FF || dbg_state !== 2'd0 || err_cnt !== 16'd3) begin
            bad++;
            $display("FAIL bp_after: in=%h state=%0d cnt=%0d expected 03ff 0 3", unit_in, dbg_state, err_cnt);
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic rs, sm;
        copy_val[0] = 8'h01; copy_val[1] = 8'h02; copy_val[2] = 8'h04;
        for (int i = 0; i < 2; i++) begin
            run_req(14'h1000 + 14'(i), 1'b0, 1'b0, lat, rs, sm);
            total++;
            if (rsp_data !== 8'h00 || rsp_err !== 8'h07 || rsp_fault !== 1'b1) begin
                bad++;
                $display("FAIL sat%0d_rsp: data=%h err=%h flt=%b expected 00 07 1", i, rsp_data, rsp_err, rsp_fault);
            end
            total++;
            if (err_cnt !== 16'(4 + i) || s_err_cnt !== 2'd3) begin
                bad++;
                $display("FAIL sat%0d_cnt: cnt=%0d sat=%0d expected %0d 3", i, err_cnt, s_err_cnt, 4 + i);
            end
            release_rsp();
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic seen;
        copy_val[0] = 8'hF0; copy_val[1] = 8'h0F; copy_val[2] = 8'h0F;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_data  = 14'h0ABC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (dbg_state !== 2'd1) begin bad++; $display("FAIL rmid_in_eval: state=%0d expected 1", dbg_state); end
        rst_n = 1'b0;
        #1;
        total++;
        if (err_cnt !== 16'h0 || s_err_cnt !== 2'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            unit_sel !== 2'd0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rmid_async: cnt=%0d sat=%0d vld=%b rdy=%b sel=%0d state=%0d expected all 0",
                     err_cnt, s_err_cnt, rsp_valid, req_ready, unit_sel, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || err_cnt !== 16'h0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_after: rsp_seen=%b cnt=%0d rdy=%b expected 0 0 1", seen, err_cnt, req_ready);
        end
    endtask

    initial begin
        copy_val[0] = 8'h00; copy_val[1] = 8'h00; copy_val[2] = 8'h00;
        test_reset();
        test_unanimous();
        test_vote();
        test_bypass();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
